// File: rtl/a2d_arb_if.sv
// Signal bundle between the A2D arbiter, its three requesters and the A2D interface.
interface a2d_arb_if;
  logic [2:0]  req;
  logic [8:0]  req_chnl;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic [2:0]  gnt;
  logic [2:0]  done;
  logic [11:0] res_out;
  logic        tmo_err;

  modport slave (
    input  req, req_chnl, cnv_cmplt, res,
    output strt_cnv, chnnl, gnt, done, res_out, tmo_err
  );

  modport master (
    output req, req_chnl, cnv_cmplt, res,
    input  strt_cnv, chnnl, gnt, done, res_out, tmo_err
  );
endinterface

// File: rtl/a2d_arb.sv
// Round-robin arbiter sharing one A2D converter among three requesters,
// with a conversion timeout that returns 12'hFFF and flags tmo_err.
module a2d_arb #(
  parameter int unsigned TMO_W = 12
) (
  input  logic      clk,
  input  logic      rst,
  a2d_arb_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       chnnl_q, chnnl_d;
  logic [2:0]       gnt_q, gnt_d;
  logic [11:0]      res_out_q, res_out_d;
  logic [1:0]       last_q, last_d;
  logic             tmo_q, tmo_d;
  logic [TMO_W-1:0] cnt_q, cnt_d, cnt_inc;

  logic [1:0]       cand;
  logic [1:0]       win_idx;
  logic             win_vld;

  // Search starts one past the previous owner so a persistent requester yields.
  always_comb begin
    cand    = '0;
    win_idx = '0;
    win_vld = 1'b0;
    for (int unsigned off = 1; off <= 3; off++) begin
      cand = 2'((32'(last_q) + off) % 3);
      if (!win_vld && bus.req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    chnnl_d   = chnnl_q;
    gnt_d     = gnt_q;
    res_out_d = res_out_q;
    last_d    = last_q;
    tmo_d     = tmo_q;
    cnt_d     = cnt_q;
    cnt_inc   = cnt_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = START;
          gnt_d   = 3'b001 << win_idx;
          chnnl_d = bus.req_chnl[3*win_idx +: 3];
          tmo_d   = 1'b0;
        end
      end
      START: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        cnt_d = cnt_inc;
        // Completion wins over a coincident terminal count.
        if (bus.cnv_cmplt) begin
          res_out_d = bus.res;
          state_d   = DONE;
        end else if (&cnt_inc) begin
          res_out_d = 12'hFFF;
          tmo_d     = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
        tmo_d   = 1'b0;
        last_d  = gnt_q[1] ? 2'd1 : (gnt_q[2] ? 2'd2 : 2'd0);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      chnnl_q   <= '0;
      gnt_q     <= '0;
      res_out_q <= '0;
      last_q    <= 2'd2;
      tmo_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      chnnl_q   <= chnnl_d;
      gnt_q     <= gnt_d;
      res_out_q <= res_out_d;
      last_q    <= last_d;
      tmo_q     <= tmo_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.strt_cnv = (state_q == START);
  assign bus.done     = (state_q == DONE) ? gnt_q : '0;
  assign bus.tmo_err  = (state_q == DONE) && tmo_q;
  assign bus.gnt      = gnt_q;
  assign bus.chnnl    = chnnl_q;
  assign bus.res_out  = res_out_q;

endmodule

// File: tb/tb_a2d_arb.sv
// Directed bench for a2d_arb: arbitration order, latency, timeout, reset abort.
module tb_a2d_arb;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   exp_idx [4];

  a2d_arb_if bus ();

  a2d_arb #(.TMO_W(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    exp_idx[0] = 0; exp_idx[1] = 1; exp_idx[2] = 2; exp_idx[3] = 0;
    rst = 1'b1;
    bus.req = '0; bus.req_chnl = '0; bus.cnv_cmplt = 1'b0; bus.res = '0;
    step(); step();
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_strt", bus.strt_cnv, 0);
    chk("rst_chnnl", bus.chnnl, 0);
    chk("rst_res", bus.res_out, 0);
    chk("rst_tmo", bus.tmo_err, 0);
    rst = 1'b0;
    step();

    // Basic conversion on channel 3, completion 10 cycles after start
    bus.req = 3'b001; bus.req_chnl = 9'd3;
    step();
    chk("t1_strt", bus.strt_cnv, 1);
    chk("t1_chnnl", bus.chnnl, 3);
    chk("t1_gnt", bus.gnt, 3'b001);
    bus.req = '0;
    step();
    chk("t1_strt_one", bus.strt_cnv, 0);
    repeat (9) step();
    chk("t1_early_done", bus.done, 0);
    bus.cnv_cmplt = 1'b1; bus.res = 12'hABC;
    step();
    chk("t1_done", bus.done, 3'b001);
    chk("t1_res", bus.res_out, 12'hABC);
    chk("t1_tmo", bus.tmo_err, 0);
    bus.cnv_cmplt = 1'b0;
    step();
    chk("t1_done_pulse", bus.done, 0);
    chk("t1_gnt_clr", bus.gnt, 0);

    // Stray completion in IDLE, then in START
    bus.cnv_cmplt = 1'b1; bus.res = 12'h123;
    step();
    chk("t4_idle_done", bus.done, 0);
    chk("t4_idle_res", bus.res_out, 12'hABC);
    bus.cnv_cmplt = 1'b0;
    bus.req = 3'b100; bus.req_chnl = {3'd5, 3'd0, 3'd0};
    step();
    chk("t4_gnt", bus.gnt, 3'b100);
    chk("t4_chnnl", bus.chnnl, 5);
    chk("t4_strt", bus.strt_cnv, 1);
    bus.cnv_cmplt = 1'b1; bus.res = 12'h456; bus.req = '0;
    step();
    chk("t4_start_done", bus.done, 0);
    chk("t4_start_res", bus.res_out, 12'hABC);
    bus.cnv_cmplt = 1'b0;
    step();
    bus.cnv_cmplt = 1'b1; bus.res = 12'h777;
    step();
    chk("t4_done", bus.done, 3'b100);
    chk("t4_res", bus.res_out, 12'h777);
    bus.cnv_cmplt = 1'b0;
    step();

    // All three requesting: order 0,1,2,0 with one idle cycle between
    bus.req = 3'b111; bus.req_chnl = {3'd6, 3'd5, 3'd4};
    step();
    for (int i = 0; i < 4; i++) begin
      chk("t2_strt", bus.strt_cnv, 1);
      chk("t2_gnt", bus.gnt, 32'(1) << exp_idx[i]);
      chk("t2_chnnl", bus.chnnl, 32'(exp_idx[i] + 4));
      step();
      bus.cnv_cmplt = 1'b1; bus.res = 12'(12'h100 + i);
      step();
      chk("t2_done", bus.done, 32'(1) << exp_idx[i]);
      chk("t2_res", bus.res_out, 32'(12'h100 + i));
      bus.cnv_cmplt = 1'b0;
      step();
      chk("t2_idle_gnt", bus.gnt, 0);
      chk("t2_idle_strt", bus.strt_cnv, 0);
      if (i == 3) bus.req = '0;
      step();
    end
    chk("t2_stay_idle", bus.strt_cnv, 0);
    chk("t2_stay_gnt", bus.gnt, 0);

    // Timeout: no completion returned
    bus.req = 3'b010; bus.req_chnl = {3'd0, 3'd2, 3'd0};
    step();
    chk("t3_gnt", bus.gnt, 3'b010);
    chk("t3_chnnl", bus.chnnl, 2);
    bus.req = '0;
    step();
    repeat (4094) step();
    chk("t3_early_done", bus.done, 0);
    step();
    chk("t3_done", bus.done, 3'b010);
    chk("t3_tmo", bus.tmo_err, 1);
    chk("t3_res", bus.res_out, 12'hFFF);
    step();
    chk("t3_tmo_pulse", bus.tmo_err, 0);
    chk("t3_done_pulse", bus.done, 0);

    // Completion on the terminal-count cycle is a normal completion
    bus.req = 3'b001; bus.req_chnl = 9'd1;
    step();
    chk("tc_gnt", bus.gnt, 3'b001);
    bus.req = '0;
    step();
    repeat (4094) step();
    bus.cnv_cmplt = 1'b1; bus.res = 12'h5A5;
    step();
    chk("tc_done", bus.done, 3'b001);
    chk("tc_tmo", bus.tmo_err, 0);
    chk("tc_res", bus.res_out, 12'h5A5);
    bus.cnv_cmplt = 1'b0;
    step();

    // Owner's channel changes during WAIT; then reset mid-conversion
    bus.req = 3'b001; bus.req_chnl = 9'd7;
    step();
    chk("t6_chnnl", bus.chnnl, 7);
    step();
    bus.req = 3'b110; bus.req_chnl = {3'd0, 3'd6, 3'd0};
    step(); step();
    chk("t6_chnnl_hold", bus.chnnl, 7);
    chk("t6_gnt_hold", bus.gnt, 3'b001);
    rst = 1'b1;
    #1;
    chk("t5_gnt", bus.gnt, 0);
    chk("t5_chnnl", bus.chnnl, 0);
    chk("t5_strt", bus.strt_cnv, 0);
    chk("t5_done", bus.done, 0);
    chk("t5_tmo", bus.tmo_err, 0);
    chk("t5_res", bus.res_out, 0);
    step();
    chk("t5_no_done", bus.done, 0);
    rst = 1'b0;
    step();
    chk("t5_gnt_after", bus.gnt, 3'b010);
    chk("t5_chnnl_after", bus.chnnl, 6);
    bus.req = '0;
    step();
    bus.cnv_cmplt = 1'b1; bus.res = 12'h321;
    step();
    chk("t5_done_after", bus.done, 3'b010);
    chk("t5_res_after", bus.res_out, 12'h321);
    bus.cnv_cmplt = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
